// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the decimal arithmetic datapath: BCD digit width,
// radix constants, the digit type and the state encoding of the digit-serial
// BCD subtractor.
// No ports (package).
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_RADIX   = 10;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  // Largest legal digit value; anything above it is a non-BCD code.
  localparam bcd_digit_t BCD_MAX_DIGIT = bcd_digit_t'(BCD_RADIX - 1);

  // Radix at the width of the signed digit difference, used to fold a
  // negative difference back into 0..9.
  localparam logic [BCD_DIGIT_W:0] BCD_RADIX_X = (BCD_DIGIT_W + 1)'(BCD_RADIX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_COMP = 2'd2,
    ST_DONE = 2'd3
  } bcd_sub_state_e;

endpackage : bcd_pkg

// File: rtl/bcd_digit_sub.sv
// -----------------------------------------------------------------------------
// bcd_digit_sub
// Combinational single-digit BCD subtract: d = x - y - bi (mod 10), bo = 1
// when the raw difference went negative. Shared by the subtraction pass and
// the ten's-complement (sign-magnitude) pass of bcd_subtractor_seq.
// Ports:
//   x   in  4  minuend digit (0..9)
//   y   in  4  subtrahend digit (0..9)
//   bi  in  1  borrow in
//   d   out 4  result digit (0..9)
//   bo  out 1  borrow out
// -----------------------------------------------------------------------------
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t x,
  input  bcd_digit_t y,
  input  logic       bi,
  output bcd_digit_t d,
  output logic       bo
);

  // Difference lies in -10..9, so one extra bit is enough to hold its sign.
  logic [BCD_DIGIT_W:0] t;
  logic [BCD_DIGIT_W:0] t_adj;

  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    d     = '0;
    bo    = 1'b0;
    t     = {1'b0, x} - {1'b0, y} - {{BCD_DIGIT_W{1'b0}}, bi};
    t_adj = t + BCD_RADIX_X;
    if (t[BCD_DIGIT_W]) begin
      d  = t_adj[BCD_DIGIT_W-1:0];
      bo = 1'b1;
    end else begin
      d  = t[BCD_DIGIT_W-1:0];
    end
  end

endmodule : bcd_digit_sub

// File: rtl/bcd_subtractor_seq.sv
// -----------------------------------------------------------------------------
// bcd_subtractor_seq
// Digit-serial packed-BCD subtractor: diff = a - b - bin, one digit per clock,
// least significant digit first, with a start/done handshake and registered
// outputs. Operand digits above 9 are flagged as invalid and skip arithmetic.
//
// Optional feature (macro BCD_SUB_SIGN_MAG_EN): when the subtraction borrows
// out of the top digit, a second digit-serial pass replaces diff with its
// ten's complement so diff holds the magnitude and neg marks the sign.
// Without the macro diff is the raw ten's-complement result and neg = bout.
//
// Parameters:
//   DIGITS   number of BCD digits per operand (>= 1)
// Ports:
//   clk      in   1          clock, rising edge
//   rst      in   1          asynchronous active-high reset
//   start    in   1          request, sampled only while idle
//   a        in   4*DIGITS   minuend, packed BCD, digit 0 = bits[3:0]
//   b        in   4*DIGITS   subtrahend, packed BCD
//   bin      in   1          borrow-in applied to digit 0
//   busy     out  1          operation in progress (accept edge .. return to idle)
//   done     out  1          one-cycle pulse, results valid
//   diff     out  4*DIGITS   result digits
//   bout     out  1          borrow out of the most significant digit
//   neg      out  1          result negative
//   invalid  out  1          some operand digit was above 9
// -----------------------------------------------------------------------------
module bcd_subtractor_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
  input  logic                        bin,
  output logic                        busy,
  output logic                        done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] diff,
  output logic                        bout,
  output logic                        neg,
  output logic                        invalid
);

  localparam int W  = BCD_DIGIT_W * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

  bcd_sub_state_e state_q, state_d;

  logic [W-1:0]  a_q, b_q;
  logic [CW-1:0] cnt_q;
  logic          borrow_q;

  logic          any_invalid;
  logic          last_digit;
  bcd_digit_t    sub_x, sub_y, sub_d;
  logic          sub_bo;
  logic [W-1:0]  diff_shifted;

  // Operand digit check, evaluated on the live inputs at the accept edge.
  always_comb begin
    any_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_MAX_DIGIT ||
          b[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_MAX_DIGIT)
        any_invalid = 1'b1;
    end
  end

  assign last_digit = (cnt_q == LAST_IDX);

  // RUN subtracts the latched operand digits; COMP subtracts the stored
  // result digit from zero, reusing the same digit cell.
  always_comb begin
    sub_x = a_q[BCD_DIGIT_W-1:0];
    sub_y = b_q[BCD_DIGIT_W-1:0];
    if (state_q == ST_COMP) begin
      sub_x = '0;
      sub_y = diff[BCD_DIGIT_W-1:0];
    end
  end

  bcd_digit_sub u_digit (
    .x  (sub_x),
    .y  (sub_y),
    .bi (borrow_q),
    .d  (sub_d),
    .bo (sub_bo)
  );

  // diff is a shift register: new digits enter at the top and, after DIGITS
  // shifts, digit 0 has reached bits[3:0]. Written without a part-select so
  // DIGITS = 1 stays legal.
  assign diff_shifted = (diff >> BCD_DIGIT_W) | (W'(sub_d) << (W - BCD_DIGIT_W));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = any_invalid ? ST_DONE : ST_RUN;
      ST_RUN: begin
        if (last_digit) begin
`ifdef BCD_SUB_SIGN_MAG_EN
          state_d = sub_bo ? ST_COMP : ST_DONE;
`else
          state_d = ST_DONE;
`endif
        end
      end
      ST_COMP: if (last_digit) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      bout     <= 1'b0;
      neg      <= 1'b0;
      invalid  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
            busy     <= 1'b1;
            diff     <= '0;
            bout     <= 1'b0;
            neg      <= 1'b0;
            invalid  <= any_invalid;
            // Invalid operands go straight to DONE, so done rises now.
            done     <= any_invalid;
          end
        end

        ST_RUN: begin
          a_q      <= a_q >> BCD_DIGIT_W;
          b_q      <= b_q >> BCD_DIGIT_W;
          diff     <= diff_shifted;
          borrow_q <= sub_bo;
          cnt_q    <= cnt_q + 1'b1;
          if (last_digit) begin
            bout     <= sub_bo;
            cnt_q    <= '0;
            // Ten's-complement pass starts with no borrow.
            borrow_q <= 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
            done     <= ~sub_bo;
`else
            done     <= 1'b1;
            neg      <= sub_bo;
`endif
          end
        end

        ST_COMP: begin
          diff     <= diff_shifted;
          borrow_q <= sub_bo;
          cnt_q    <= cnt_q + 1'b1;
          if (last_digit) begin
            neg  <= 1'b1;
            done <= 1'b1;
          end
        end

        ST_DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end

        default: ;
      endcase
    end
  end

endmodule : bcd_subtractor_seq
